// File: rtl/npu_pe_seq_ctrl_if.sv
// Configuration, input-FIFO handshake and PE-chain drive signals of the PE sequencer.
interface npu_pe_seq_ctrl_if #(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
);
  logic              cfg_start;
  logic [IN_W-1:0]   cfg_num_inputs;
  logic [ADDR_W-1:0] cfg_weight_base;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              npu_pe_new_input_wren;
  logic [DATA_W-1:0] npu_pe_data_out;
  logic [ADDR_W-1:0] weight_rd_addr;
  logic              npu_pe_en;
  logic              sig_valid;
  logic              busy;
  logic              done;
  logic [IN_W-1:0]   step_count;

  // Environment side: issues configuration and supplies input words.
  modport master (
    output cfg_start, cfg_num_inputs, cfg_weight_base, in_valid, in_data,
    input  in_ready, npu_pe_new_input_wren, npu_pe_data_out, weight_rd_addr,
           npu_pe_en, sig_valid, busy, done, step_count
  );

  // Sequencer side.
  modport slave (
    input  cfg_start, cfg_num_inputs, cfg_weight_base, in_valid, in_data,
    output in_ready, npu_pe_new_input_wren, npu_pe_data_out, weight_rd_addr,
           npu_pe_en, sig_valid, busy, done, step_count
  );
endinterface

// File: rtl/npu_pe_seq_ctrl.sv
// PE-chain sequencer: per input word LOAD -> FETCH -> MAC, then drain the
// multiply-add pipeline and flag the result to the sigmoid unit.
module npu_pe_seq_ctrl #(
  parameter int unsigned IN_W     = 8,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned PIPE_LAT = 3   // must be >= 1
) (
  input  logic             CLK,
  input  logic             npu_rst,
  npu_pe_seq_ctrl_if.slave bus
);

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] FETCH = 3'd2;
  localparam logic [2:0] MAC   = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]         state_q,  state_d;
  logic [IN_W-1:0]    m_q,      m_d;
  logic [ADDR_W-1:0]  base_q,   base_d;
  logic [IN_W-1:0]    step_q,   step_d;
  logic [DRAIN_W-1:0] drain_q,  drain_d;
  logic [DATA_W-1:0]  data_q,   data_d;
  logic [ADDR_W-1:0]  addr_q,   addr_d;
  logic               wren_q,   wren_d;
  logic               en_q,     en_d;
  logic               sig_q,    sig_d;
  logic               done_q,   done_d;
  logic               busy_q,   busy_d;
  logic [IN_W-1:0]    step_inc;

  assign step_inc = step_q + IN_W'(1);

  // State and registered outputs; synchronous reset aborts any pass in flight.
  always_ff @(posedge CLK) begin
    if (npu_rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      base_q  <= '0;
      step_q  <= '0;
      drain_q <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wren_q  <= 1'b0;
      en_q    <= 1'b0;
      sig_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      base_q  <= base_d;
      step_q  <= step_d;
      drain_q <= drain_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wren_q  <= wren_d;
      en_q    <= en_d;
      sig_q   <= sig_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next state; strobes are registered so they line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    base_d  = base_q;
    step_d  = step_q;
    drain_d = drain_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wren_d  = 1'b0;
    en_d    = 1'b0;
    sig_d   = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cfg_start) begin
          m_d     = bus.cfg_num_inputs;
          base_d  = bus.cfg_weight_base;
          step_d  = '0;
          state_d = (bus.cfg_num_inputs == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          addr_d  = base_q + ADDR_W'(step_q);
          wren_d  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        en_d    = 1'b1;
        state_d = MAC;
      end
      MAC: begin
        step_d = step_inc;
        if (step_inc == m_q) begin
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          state_d = LOAD;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_W'(PIPE_LAT - 1)) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        sig_d   = (m_q != '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.in_ready              = (state_q == LOAD) && !npu_rst;
  assign bus.npu_pe_new_input_wren = wren_q;
  assign bus.npu_pe_data_out       = data_q;
  assign bus.weight_rd_addr        = addr_q;
  assign bus.npu_pe_en             = en_q;
  assign bus.sig_valid             = sig_q;
  assign bus.busy                  = busy_q;
  assign bus.done                  = done_q;
  assign bus.step_count            = step_q;

endmodule
